// File: rtl/dadd_sched.sv
// dadd_sched: per-pixel scheduler for the blitter data adder.
// Walks the enabled add steps (PAT, GOURD, GOURZ, SRCZ1, SRCZ2) in fixed
// order, driving the adder operand selects/mode for ADD_LAT cycles each.
// Optional feature macro: DADD_SRCZ_EN (adds the SRCZ1/SRCZ2 steps).
module dadd_sched #(
   parameter int ADD_LAT = 1
) (
   input  logic        sys_clk,
   input  logic        reset,
   input  logic        cmdld,
   input  logic [31:0] gpu_din,
   input  logic        pix_start,
   input  logic        stall,
   output logic        pix_busy,
   output logic        pix_done,
   output logic [2:0]  daddasel,
   output logic [2:0]  daddbsel,
   output logic [2:0]  daddmode,
   output logic        daddq_sel,
   output logic        daddld
);

`ifdef DADD_SRCZ_EN
   localparam int CMD_W = 6;
   typedef enum logic [2:0] {S_IDLE, S_PAT, S_GOURD, S_GOURZ, S_SRCZ1, S_SRCZ2} state_t;
`else
   localparam int CMD_W = 4;
   typedef enum logic [2:0] {S_IDLE, S_PAT, S_GOURD, S_GOURZ} state_t;
`endif

   localparam logic [1:0] LAST = 2'(ADD_LAT - 1);

   state_t             state_q, state_d;
   logic [1:0]         cnt_q, cnt_d;
   logic [CMD_W-1:0]   cmd_q, cmd_d;
   logic [CMD_W-1:0]   pend_q, pend_d;
   logic               pend_v_q, pend_v_d;
   logic               done_q, done_d;

   // Command bits outside the stored field have no function here.
   logic unused_din;
   assign unused_din = ^gpu_din[31:CMD_W];

   // First enabled step strictly after cur; checked last-to-first so the
   // earliest enabled step wins. PATDADD/PATFADD share one PAT step.
   function automatic state_t next_step(input state_t cur, input logic [CMD_W-1:0] c);
      next_step = S_IDLE;
`ifdef DADD_SRCZ_EN
      if (cur < S_SRCZ2 && c[5]) next_step = S_SRCZ2;
      if (cur < S_SRCZ1 && c[4]) next_step = S_SRCZ1;
`endif
      if (cur < S_GOURZ && c[3]) next_step = S_GOURZ;
      if (cur < S_GOURD && c[2]) next_step = S_GOURD;
      if (cur == S_IDLE && (c[0] || c[1])) next_step = S_PAT;
   endfunction

   // State, counter, command and pending registers.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 2'd0;
         cmd_q    <= '0;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cmd_q    <= cmd_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         done_q   <= done_d;
      end
   end

   // Sequencing: start, step advance, command/pending handling.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cmd_d    = cmd_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      done_d   = 1'b0;
      if (state_q == S_IDLE) begin
         if (cmdld) cmd_d = gpu_din[CMD_W-1:0];
         if (pix_start) begin
            state_d = next_step(S_IDLE, cmd_q);
            cnt_d   = 2'd0;
            if (state_d == S_IDLE) done_d = 1'b1;
         end
      end else begin
         if (cmdld) begin
            pend_d   = gpu_din[CMD_W-1:0];
            pend_v_d = 1'b1;
         end
         if (!stall) begin
            if (cnt_q == LAST) begin
               state_d = next_step(state_q, cmd_q);
               cnt_d   = 2'd0;
               if (state_d == S_IDLE) begin
                  done_d = 1'b1;
                  // Latest pending command becomes live as we go idle.
                  if (pend_v_d) cmd_d = pend_d;
                  pend_v_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
      end
   end

   // Per-step adder controls; load strobe only on the last unstalled cycle.
   always_comb begin
      daddasel  = 3'd0;
      daddbsel  = 3'd0;
      daddmode  = 3'd0;
      daddq_sel = 1'b0;
      case (state_q)
         S_GOURD: begin daddasel = 3'd1; daddbsel = 3'd1; daddmode = 3'd3; daddq_sel = 1'b1; end
         S_GOURZ: begin daddasel = 3'd2; daddbsel = 3'd2; daddmode = 3'd1; daddq_sel = 1'b1; end
`ifdef DADD_SRCZ_EN
         S_SRCZ1: begin daddasel = 3'd3; daddbsel = 3'd3; end
         S_SRCZ2: begin daddasel = 3'd4; daddbsel = 3'd4; end
`endif
         default: ;
      endcase
   end

   assign pix_busy = (state_q != S_IDLE);
   assign pix_done = done_q;
   assign daddld   = pix_busy && (cnt_q == LAST) && !stall;

endmodule

// File: tb/tb_dadd_sched.sv
// Directed bench for dadd_sched: one instance with ADD_LAT=1, one with ADD_LAT=2.
module tb_dadd_sched;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic        a_rst = 1'b1, a_cmdld = 1'b0, a_start = 1'b0, a_stall = 1'b0;
   logic [31:0] a_din = '0;
   logic        a_busy, a_done, a_qsel, a_ld;
   logic [2:0]  a_asel, a_bsel, a_mode;

   logic        b_rst = 1'b1, b_cmdld = 1'b0, b_start = 1'b0, b_stall = 1'b0;
   logic [31:0] b_din = '0;
   logic        b_busy, b_done, b_qsel, b_ld;
   logic [2:0]  b_asel, b_bsel, b_mode;

   dadd_sched #(.ADD_LAT(1)) ua (
      .sys_clk(clk), .reset(a_rst), .cmdld(a_cmdld), .gpu_din(a_din),
      .pix_start(a_start), .stall(a_stall), .pix_busy(a_busy), .pix_done(a_done),
      .daddasel(a_asel), .daddbsel(a_bsel), .daddmode(a_mode),
      .daddq_sel(a_qsel), .daddld(a_ld));

   dadd_sched #(.ADD_LAT(2)) ub (
      .sys_clk(clk), .reset(b_rst), .cmdld(b_cmdld), .gpu_din(b_din),
      .pix_start(b_start), .stall(b_stall), .pix_busy(b_busy), .pix_done(b_done),
      .daddasel(b_asel), .daddbsel(b_bsel), .daddmode(b_mode),
      .daddq_sel(b_qsel), .daddld(b_ld));

   wire [12:0] a_obs = {a_busy, a_done, a_asel, a_bsel, a_mode, a_qsel, a_ld};
   wire [12:0] b_obs = {b_busy, b_done, b_asel, b_bsel, b_mode, b_qsel, b_ld};

   function automatic logic [12:0] pk(input logic busy, input logic done, input logic [2:0] as,
                                      input logic [2:0] bs, input logic [2:0] md,
                                      input logic q, input logic ld);
      return {busy, done, as, bs, md, q, ld};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("chk %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // step tables: PAT, GOURD, GOURZ, SRCZ1, SRCZ2
   logic [2:0] t_sel  [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
   logic [2:0] t_mode [5] = '{3'd0, 3'd3, 3'd1, 3'd0, 3'd0};
   logic       t_q    [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

   localparam logic [12:0] IDLE0 = 13'd0;
   localparam logic [12:0] DONE  = 13'h0800;

   initial begin
      int nfull;
`ifdef DADD_SRCZ_EN
      nfull = 5;
`else
      nfull = 3;
`endif
      step(); step();
      a_rst = 1'b0; b_rst = 1'b0;
      chk("a_reset", a_obs, IDLE0);
      chk("b_reset", b_obs, IDLE0);

      // ---- A: cmd 0x0C, GOURD then GOURZ ----
      a_cmdld = 1'b1; a_din = 32'h0000_000C; step(); a_cmdld = 1'b0;
      a_start = 1'b1; step(); a_start = 1'b0;
      chk("a_gourd", a_obs, pk(1, 0, 1, 1, 3, 1, 1));
      step(); chk("a_gourz", a_obs, pk(1, 0, 2, 2, 1, 1, 1));
      step(); chk("a_done", a_obs, DONE);
      step(); chk("a_idle", a_obs, IDLE0);

      // ---- A: back-to-back, one done every 3 cycles ----
      a_start = 1'b1;
      for (int r = 0; r < 2; r++) begin
         step(); chk("a_b2b_gourd", a_obs, pk(1, 0, 1, 1, 3, 1, 1));
         step(); chk("a_b2b_gourz", a_obs, pk(1, 0, 2, 2, 1, 1, 1));
         step(); chk("a_b2b_done", a_obs, DONE);
      end
      a_start = 1'b0;
      step(); chk("a_b2b_idle", a_obs, IDLE0);

      // ---- A: N=0 ----
      a_cmdld = 1'b1; a_din = 32'hFFFF_FFC0; step(); a_cmdld = 1'b0;
      a_start = 1'b1; step(); a_start = 1'b0;
      chk("a_n0_done", a_obs, DONE);
      step(); chk("a_n0_idle", a_obs, IDLE0);

      // ---- A: reset mid-GOURZ clears command ----
      a_cmdld = 1'b1; a_din = 32'h0000_000C; step(); a_cmdld = 1'b0;
      a_start = 1'b1; step(); a_start = 1'b0;
      step(); chk("a_rst_gourz", a_obs, pk(1, 0, 2, 2, 1, 1, 1));
      a_rst = 1'b1; step(); a_rst = 1'b0;
      chk("a_rst_zero", a_obs, IDLE0);
      step(); chk("a_rst_nodone", a_obs, IDLE0);
      a_start = 1'b1; step(); a_start = 1'b0;
      chk("a_rst_cmd0", a_obs, DONE);

      // ---- B: cmd 0x3F, full sequence with ADD_LAT=2 ----
      b_cmdld = 1'b1; b_din = 32'h0000_003F; step(); b_cmdld = 1'b0;
      b_start = 1'b1; step(); b_start = 1'b0;
      for (int s = 0; s < nfull; s++) begin
         for (int c = 0; c < 2; c++) begin
            chk($sformatf("b_full_s%0d_c%0d", s, c), b_obs,
                pk(1, 0, t_sel[s], t_sel[s], t_mode[s], t_q[s], c == 1));
            step();
         end
      end
      chk("b_full_done", b_obs, DONE);

      // ---- B: stall in 2nd GOURD cycle ----
      b_cmdld = 1'b1; b_din = 32'h0000_0004; step(); b_cmdld = 1'b0;
      b_start = 1'b1; step(); b_start = 1'b0;
      chk("b_st_c0", b_obs, pk(1, 0, 1, 1, 3, 1, 0));
      step(); b_stall = 1'b1; #1;
      chk("b_st_hold1", b_obs, pk(1, 0, 1, 1, 3, 1, 0));
      step(); chk("b_st_hold2", b_obs, pk(1, 0, 1, 1, 3, 1, 0));
      step(); chk("b_st_hold3", b_obs, pk(1, 0, 1, 1, 3, 1, 0));
      b_stall = 1'b0; #1;
      chk("b_st_release", b_obs, pk(1, 0, 1, 1, 3, 1, 1));
      step(); chk("b_st_done", b_obs, DONE);

      // ---- B: pending commands while busy, last wins ----
      b_start = 1'b1; step(); b_start = 1'b0;
      b_cmdld = 1'b1; b_din = 32'h0000_0008;
      chk("b_pend_c0", b_obs, pk(1, 0, 1, 1, 3, 1, 0));
      step(); b_din = 32'h0000_0030;
      chk("b_pend_c1", b_obs, pk(1, 0, 1, 1, 3, 1, 1));
      step(); b_cmdld = 1'b0;
      chk("b_pend_done", b_obs, DONE);
      b_start = 1'b1; step(); b_start = 1'b0;
`ifdef DADD_SRCZ_EN
      chk("b_pend_z1a", b_obs, pk(1, 0, 3, 3, 0, 0, 0));
      step(); chk("b_pend_z1b", b_obs, pk(1, 0, 3, 3, 0, 0, 1));
      step(); chk("b_pend_z2a", b_obs, pk(1, 0, 4, 4, 0, 0, 0));
      step(); chk("b_pend_z2b", b_obs, pk(1, 0, 4, 4, 0, 0, 1));
      step(); chk("b_pend_z_done", b_obs, DONE);
`else
      chk("b_pend_n0_done", b_obs, DONE);
`endif
      step(); chk("b_end_idle", b_obs, IDLE0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
